// File: rtl/lut_config_loader_pkg.sv
// Shared definitions for the LUT configuration loader: FSM state encoding
// and the elaboration-time helpers that size the beat and LUT counters.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lut_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_DONE  = DONE;

  function automatic int calc_beats(input int mem_size, input int shift_width);
    return mem_size / shift_width;
  endfunction

  // A counter for n values never drops below one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Stream-in and LUT-configuration bus of the loader, bundled for port lists.
// A beat moves on a rising edge where bit_valid && bit_ready; bit_in must be
// held stable while bit_valid is high, and bit_ready never depends on bit_valid.
interface lut_config_loader_if #(
  parameter int MEM_SIZE    = 16,
  parameter int NUM_LUTS    = 4,
  parameter int SHIFT_WIDTH = 1
);
  logic [SHIFT_WIDTH-1:0] bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [MEM_SIZE-1:0]    config_in;
  logic [NUM_LUTS-1:0]    config_en;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, config_in, config_en
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, config_in, config_en
  );
endinterface

// File: rtl/lut_config_loader_shift_reg.sv
// Word assembler: shifts beats in at the LSB end so the first beat of a word
// ends up in the MSBs; the register doubles as the shared config_in bus.
module cfg_shift_reg #(
  parameter int MEM_SIZE    = 16,
  parameter int SHIFT_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_shift_en,
  input  logic [SHIFT_WIDTH-1:0] i_data,
  output logic [MEM_SIZE-1:0]    o_word
);
  logic [MEM_SIZE-1:0] r_sr;

  // Truncating the concatenation drops the oldest beat and also covers the
  // single-beat case where MEM_SIZE equals SHIFT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_shift_en) begin
      r_sr <= MEM_SIZE'({r_sr, i_data});
    end
  end

  assign o_word = r_sr;
endmodule

// File: rtl/lut_config_loader.sv
// Serial LUT configuration loader: assembles MEM_SIZE-bit words from a beat
// stream and writes them to NUM_LUTS LUTs in turn with a one-hot strobe.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS      = 4,
  parameter int MEM_SIZE    = 2 ** INPUTS,
  parameter int NUM_LUTS    = 4,
  parameter int SHIFT_WIDTH = 1
) (
  input  logic                config_clk,
  input  logic                config_rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [1:0]          o_dbg_state,
  lut_config_loader_if.slave  cfg_bus
);
  localparam int BEATS = calc_beats(MEM_SIZE, SHIFT_WIDTH);
  localparam int CNT_W = cnt_width(BEATS);
  localparam int IDX_W = cnt_width(NUM_LUTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_LUT  = IDX_W'(NUM_LUTS - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [IDX_W-1:0]    r_lut_idx;
  logic                w_shift_en;
  logic                w_last_beat;
  logic [MEM_SIZE-1:0] w_word;

  // Abort wins over a beat presented in the same cycle.
  assign w_shift_en  = (r_state == ST_SHIFT) && cfg_bus.bit_valid && !abort;
  assign w_last_beat = w_shift_en && (r_beat_cnt == LAST_BEAT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (abort)            w_next_state = ST_IDLE;
        else if (w_last_beat) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)                      w_next_state = ST_IDLE;
        else if (r_lut_idx == LAST_LUT) w_next_state = ST_DONE;
        else                            w_next_state = ST_SHIFT;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counters saturate at their last value and are cleared only on entry to a word.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      r_beat_cnt <= '0;
      r_lut_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_beat_cnt <= '0;
            r_lut_idx  <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_shift_en && (r_beat_cnt != LAST_BEAT)) r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        ST_WRITE: begin
          if (!abort && (r_lut_idx != LAST_LUT)) begin
            r_lut_idx  <= r_lut_idx + 1'b1;
            r_beat_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  cfg_shift_reg #(
    .MEM_SIZE    (MEM_SIZE),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift_reg (
    .clk        (config_clk),
    .rst_n      (config_rst_n),
    .i_shift_en (w_shift_en),
    .i_data     (cfg_bus.bit_in),
    .o_word     (w_word)
  );

  assign cfg_bus.config_in = w_word;
  assign cfg_bus.config_en = (r_state == ST_WRITE) ? (NUM_LUTS'(1) << r_lut_idx) : '0;
  assign cfg_bus.bit_ready = (r_state == ST_SHIFT);
  assign busy              = (r_state != ST_IDLE);
  assign done              = (r_state == ST_DONE);
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: reference words come from the beats the driver
// sends; a negedge monitor matches every strobe and done pulse against them.
module tb_lut_config_loader;
  import lut_cfg_pkg::*;

  localparam int INPUTS = 2;
  localparam int MEM    = 4;
  localparam int NL     = 2;
  localparam int SW     = 1;
  localparam int BEATS  = MEM / SW;
  localparam int W      = 1 + NL + MEM;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done;
  logic [1:0] dbg_state;

  lut_config_loader_if #(.MEM_SIZE(MEM), .NUM_LUTS(NL), .SHIFT_WIDTH(SW)) bus ();

  lut_config_loader #(
    .INPUTS(INPUTS), .MEM_SIZE(MEM), .NUM_LUTS(NL), .SHIFT_WIDTH(SW)
  ) u_dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .o_dbg_state  (dbg_state),
    .cfg_bus      (bus)
  );

  // Two-bit beats, single LUT.
  logic       w_start = 1'b0;
  logic       w_abort = 1'b0;
  logic       w_busy, w_done;
  logic [1:0] w_dbg_state;

  lut_config_loader_if #(.MEM_SIZE(4), .NUM_LUTS(1), .SHIFT_WIDTH(2)) w_bus ();

  lut_config_loader #(
    .INPUTS(2), .MEM_SIZE(4), .NUM_LUTS(1), .SHIFT_WIDTH(2)
  ) u_dut_wide (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .start        (w_start),
    .abort        (w_abort),
    .busy         (w_busy),
    .done         (w_done),
    .o_dbg_state  (w_dbg_state),
    .cfg_bus      (w_bus)
  );

  // scoreboard
  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  int strobe_cyc[NL];
  int done_cyc;
  int start_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry format: {is_done, config_en, config_in}; config_in is don't-care on done.
  always @(negedge clk) begin
    if (rst_n && ((bus.config_en != '0) || done)) begin
      mon_act = {done, bus.config_en, done ? {MEM{1'b0}} : bus.config_in};
      if (exp_q.size() == 0) begin
        total_cnt++;
        bad_cnt++;
        $display("FAIL unexpected_output: got %0h expected nothing", mon_act);
      end else begin
        check("scoreboard", mon_act, exp_q.pop_front());
      end
      for (int k = 0; k < NL; k++) if (bus.config_en[k]) strobe_cyc[k] = cyc;
      if (done) done_cyc = cyc;
    end
  end

  // driver: one load pass, fixed or random beats, optional stall/abort/spurious start
  task automatic run_pass(input bit rnd, input logic [7:0] bits, input int stall_at,
                          input int stall_len, input int abort_at, input bit noisy);
    logic [MEM-1:0] word;
    logic [NL-1:0]  en;
    logic [SW-1:0]  b;
    int nb, lut, tot, stalled;
    bit fin, aborted, v;
    word = '0; nb = 0; lut = 0; tot = 0; stalled = 0; fin = 0; aborted = 0;
    for (int k = 0; k < NL; k++) strobe_cyc[k] = -1;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 300 && !fin; t++) begin
      if (t > 0) @(negedge clk);
      abort = 1'b0;
      bus.bit_valid = 1'b0;
      start = (noisy && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (aborted) begin
        check("abort_busy", 32'(busy), 0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_en", 32'(bus.config_en), 0);
        fin = 1;
      end else if (bus.bit_ready) begin
        b = rnd ? SW'($urandom) : bits[7 - tot];
        bus.bit_in = b;
        if (tot == abort_at) begin
          abort = 1'b1;
          bus.bit_valid = 1'b1;
          aborted = 1;
        end else begin
          v = rnd ? ($urandom_range(0, 9) < 7) : !(tot == stall_at && stalled < stall_len);
          if (!v) stalled++;
          bus.bit_valid = v;
          if (v) begin
            word = (word << SW) | MEM'(b);
            nb++;
            tot++;
            if (nb == BEATS) begin
              en = '0;
              en[lut] = 1'b1;
              exp_q.push_back({1'b0, en, word});
              lut++;
              nb = 0;
              word = '0;
              if (lut == NL) exp_q.push_back({1'b1, {NL{1'b0}}, {MEM{1'b0}}});
            end
          end
        end
      end else if (!busy) begin
        fin = 1;
      end
    end
    if (!fin) begin
      total_cnt++;
      bad_cnt++;
      $display("FAIL pass_timeout: got busy=%0d expected idle within 300 cycles", busy);
    end
    abort = 1'b0;
    start = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_pass();
    logic [MEM-1:0] word;
    int nb;
    bit hit;
    word = '0; nb = 0; hit = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      if (t > 0) @(negedge clk);
      bus.bit_valid = 1'b0;
      if (bus.config_en != '0) begin
        hit = 1;
      end else if (bus.bit_ready && nb < BEATS) begin
        bus.bit_in = SW'($urandom);
        bus.bit_valid = 1'b1;
        word = (word << SW) | MEM'(bus.bit_in);
        nb++;
        if (nb == BEATS) exp_q.push_back({1'b0, NL'(1), word});
      end
    end
    if (!hit) begin
      total_cnt++;
      bad_cnt++;
      $display("FAIL rst_wait: got no strobe expected one within 50 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_en", 32'(bus.config_en), 0);
    check("rst_word", 32'(bus.config_in), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_queue", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic wide_pass(input logic [1:0] b0, input logic [1:0] b1);
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    w_bus.bit_valid = 1'b1;
    w_bus.bit_in = b0;
    @(negedge clk);
    w_bus.bit_in = b1;
    @(negedge clk);
    w_bus.bit_valid = 1'b0;
    check("wide_en", 32'(w_bus.config_en), 1);
    check("wide_word", 32'(w_bus.config_in), 32'({b0, b1}));
    @(negedge clk);
    check("wide_done", 32'(w_done), 1);
    @(negedge clk);
    check("wide_idle", 32'(w_busy), 0);
  endtask

  initial begin
    int ab;
    bus.bit_in = '0;
    bus.bit_valid = 1'b0;
    w_bus.bit_in = '0;
    w_bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.bit_ready), 0);
    check("reset_word", 32'(bus.config_in), 0);
    check("reset_en", 32'(bus.config_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(1'b0, 8'b10110110, -1, 0, -1, 1'b0);
    check("basic_lut0_cycle", 32'(strobe_cyc[0] - start_cyc + 1), 5);
    check("basic_lut1_cycle", 32'(strobe_cyc[1] - start_cyc + 1), 10);
    check("basic_done_cycle", 32'(done_cyc - start_cyc + 1), 11);

    run_pass(1'b0, 8'b10110110, 2, 3, -1, 1'b0);
    check("stall_lut0_cycle", 32'(strobe_cyc[0] - start_cyc + 1), 8);
    check("stall_lut1_cycle", 32'(strobe_cyc[1] - start_cyc + 1), 13);
    check("stall_done_cycle", 32'(done_cyc - start_cyc + 1), 14);

    run_pass(1'b0, 8'b10110110, -1, 0, 6, 1'b0);
    check("abort_lut0_cycle", 32'(strobe_cyc[0] - start_cyc + 1), 5);
    check("abort_no_lut1", 32'(strobe_cyc[1]), 32'(-1));
    check("abort_no_done", 32'(done_cyc), 32'(-1));

    run_pass(1'b0, 8'b10110110, -1, 0, -1, 1'b1);
    check("nstart_lut0_cycle", 32'(strobe_cyc[0] - start_cyc + 1), 5);
    check("nstart_lut1_cycle", 32'(strobe_cyc[1] - start_cyc + 1), 10);
    check("nstart_done_cycle", 32'(done_cyc - start_cyc + 1), 11);

    reset_mid_pass();
    run_pass(1'b1, 8'h00, -1, 0, -1, 1'b0);
    check("after_rst_lut0_first", 32'(strobe_cyc[0] < strobe_cyc[1]), 1);

    for (int i = 0; i < 20; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_pass(1'b1, 8'h00, -1, 0, ab, 1'($urandom_range(0, 1)));
    end

    wide_pass(2'b10, 2'b01);
    for (int i = 0; i < 3; i++) wide_pass(2'($urandom), 2'($urandom));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/lut_config_loader.md
# lut_config_loader

Configuration front-end for a bank of LUTs. Accepts a serial configuration stream over a valid/ready handshake and assembles it into MEM_SIZE-bit words. Writes each word to one LUT in turn by driving the shared `config_in` bus with a one-cycle, one-hot `config_en` strobe. Sits directly upstream of the LUT bank, in the `config_clk` domain.

## Interface
- `INPUTS`, 4: LUT address width.
- `MEM_SIZE`, 2**INPUTS: bits per LUT word.
- `NUM_LUTS`, 4: number of LUTs loaded per pass. Must be ≥ 1.
- `SHIFT_WIDTH`, 1: bits per stream beat. MEM_SIZE must be a multiple of SHIFT_WIDTH.
- `config_clk`  in  1  sole clock, rising edge.
- `config_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load pass; sampled only in IDLE.
- `abort`  in  1  cancel the current pass.
- `bit_in`  in  SHIFT_WIDTH  stream data beat.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  loader accepts a beat this cycle.
- `config_in`  out  MEM_SIZE  assembled word; shared by all LUTs.
- `config_en`  out  NUM_LUTS  one-hot write strobe; bit k targets LUT k.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a pass completes.

## Operation
- BEATS = MEM_SIZE/SHIFT_WIDTH. A beat is accepted on a rising edge where `bit_valid && bit_ready`.
- Shift register: `sr <= {sr[MEM_SIZE-SHIFT_WIDTH-1:0], bit_in}` on each accepted beat. The first beat of a word ends in the MSBs. `config_in` = `sr`.
- FSM states are IDLE, SHIFT, WRITE, DONE.
  - IDLE: `bit_ready`=0. On `start`: clear the beat counter and `lut_idx`, then go to SHIFT.
  - SHIFT: `bit_ready`=1. When beat number BEATS-1 is accepted, go to WRITE.
  - WRITE: lasts one cycle. `config_en` = 1<<`lut_idx`, `bit_ready`=0, `sr` frozen.
    - If `lut_idx`==NUM_LUTS-1, go to DONE.
    - Otherwise increment `lut_idx`, clear the beat counter, and go to SHIFT.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `abort` in SHIFT or WRITE:
  - Next state is IDLE, and `config_en` is forced to 0 on that edge.
  - The partial word is discarded; LUTs already written stay written.
  - `abort` has priority over `start` and over beat acceptance in the same cycle.
- `bit_valid` low in SHIFT stalls the counter; there is no timeout.
- Counter widths: beat counter is $clog2(BEATS) bits (min 1), `lut_idx` is $clog2(NUM_LUTS) bits (min 1). Neither wraps; both are cleared explicitly.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset values: `bit_ready`=0, `config_in`=0, `config_en`=0, `busy`=0, `done`=0. FSM resets to IDLE.
- Reset mid-pass returns to IDLE immediately and no strobe is issued.
- `config_in` and `config_en` are stable across the entire WRITE cycle, so the LUT captures the word on the edge that ends WRITE.
- With `start` sampled at edge 0 and `bit_valid` held high:
  - Beats are accepted at edges 1..BEATS.
  - LUT k is strobed in cycle (k+1)(BEATS+1).
  - `done` is high in cycle NUM_LUTS·(BEATS+1)+1.
  - `busy` falls one cycle after that.
- Throughput is BEATS+1 cycles per LUT.

## Structure
- Shared package `lut_cfg_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, WRITE, DONE);
  - a localparam function computing BEATS and the counter widths.
- One natural sub-module, `cfg_shift_reg` (parameters MEM_SIZE, SHIFT_WIDTH; inputs shift enable and data; parallel output). Counters and the FSM live in the top level.

## Test plan
All scenarios use INPUTS=2, MEM_SIZE=4, NUM_LUTS=2, SHIFT_WIDTH=1 unless noted.
- Basic pass: `start`, then beats 1,0,1,1,0,1,1,0 with valid always high → `config_in`=4'b1011 and `config_en`=2'b01 in cycle 5; `config_in`=4'b0110 and `config_en`=2'b10 in cycle 10; `done` pulse in cycle 11.
- Stall: drop `bit_valid` for 3 cycles after the second beat → LUT0 strobe moves to cycle 8; word unchanged.
- Abort: assert `abort` after 2 beats of LUT1 → `config_en` never shows 2'b10, no `done` pulse, IDLE next cycle, `busy`=0.
- Reset mid-pass: drop `config_rst_n` during WRITE → `config_en`=0 and `config_in`=0 immediately; the next `start` loads from LUT0.
- Wide beats (SHIFT_WIDTH=2): beats 2'b10, 2'b01 → `config_in`=4'b1001 strobed in cycle 3.
- Ignored `start`: pulse `start` while busy → pass timing is identical to the basic pass; no restart.
